// File: rtl/rvi_bj_redirect_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rvi_bj_ctrl_pkg
// Description : Shared types and helpers for the branch/jump redirect
//               controller (FSM states, recovery causes, drain width).
// Revision    : 1.0 - initial release
// ============================================================================
package rvi_bj_ctrl_pkg;

    // Recovery sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REDIR = 2'd1,
        ST_DRAIN = 2'd2,
        ST_EXC   = 2'd3
    } bj_state_t;

    // Why a resolved branch/jump needs recovery
    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_MISPRED  = 2'd1,
        CAUSE_MISALIGN = 2'd2
    } bj_cause_t;

    // Drain counter width; never narrower than one bit so DRAIN_CYC=0 still
    // yields a legal vector.
    function automatic int drainCntW(input int drainCyc);
        int w;
        w = $clog2(drainCyc + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rvi_bj_redirect_ctrl_mispred_chk.sv
`default_nettype none
// ============================================================================
// Module      : rvi_bj_mispred_chk
// Description : Pure combinational compare of the resolved branch/jump result
//               against the front-end prediction; flags mispredict and
//               target misalignment and selects the architecturally correct PC.
// Revision    : 1.0 - initial release
// ============================================================================
module rvi_bj_mispred_chk
    import rvi_bj_ctrl_pkg::*;
#(
    parameter int CPU_WIDTH = 32,
    parameter bit RVC       = 1'b1
) (
    input  logic                 ex_taken_i,
    input  logic [CPU_WIDTH-1:0] ex_tgt_i,
    input  logic [CPU_WIDTH-1:0] ex_link_pc_i,
    input  logic                 ex_pred_taken_i,
    input  logic [CPU_WIDTH-1:0] ex_pred_tgt_i,
    output logic                 mispred,
    output logic                 misalign,
    output logic [CPU_WIDTH-1:0] correct_pc
);

    logic w_tgtLowBad;

    // With compressed instructions only bit 0 must be clear; otherwise the
    // target must be word aligned.
    if (RVC) begin : g_rvc
        assign w_tgtLowBad = ex_tgt_i[0];
    end else begin : g_norvc
        assign w_tgtLowBad = |ex_tgt_i[1:0];
    end

    assign misalign   = ex_taken_i & w_tgtLowBad;
    assign mispred    = (ex_taken_i != ex_pred_taken_i) |
                        (ex_taken_i & (ex_tgt_i != ex_pred_tgt_i));
    assign correct_pc = ex_taken_i ? ex_tgt_i : ex_link_pc_i;

endmodule
`default_nettype wire

// File: rtl/rvi_bj_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rvi_bj_redirect_ctrl
// Description : Branch/jump recovery controller. Accepts resolved results,
//               issues fetch redirects with flush/kill/drain sequencing or a
//               target-misaligned exception, and keeps saturating branch and
//               mispredict statistics. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module rvi_bj_redirect_ctrl
    import rvi_bj_ctrl_pkg::*;
#(
    parameter int RV64      = 0,
    parameter int CPU_WIDTH = 32 * (RV64 + 1),
    parameter int RVC       = 1,
    parameter int DRAIN_CYC = 2,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ex_vld_i,
    output logic                 ex_rdy_o,
    input  logic                 ex_is_bj_i,
    input  logic                 ex_taken_i,
    input  logic [CPU_WIDTH-1:0] ex_tgt_i,
    input  logic [CPU_WIDTH-1:0] ex_link_pc_i,
    input  logic                 ex_pred_taken_i,
    input  logic [CPU_WIDTH-1:0] ex_pred_tgt_i,
    output logic                 redir_vld_o,
    input  logic                 redir_rdy_i,
    output logic [CPU_WIDTH-1:0] redir_pc_o,
    output logic                 flush_o,
    output logic                 kill_o,
    output logic                 exc_vld_o,
    input  logic                 exc_rdy_i,
    output logic [CPU_WIDTH-1:0] exc_addr_o,
    output logic [CNT_W-1:0]     bj_cnt_o,
    output logic [CNT_W-1:0]     mispred_cnt_o
);

    localparam int                  c_DRAIN_W    = drainCntW(DRAIN_CYC);
    localparam logic [c_DRAIN_W-1:0] c_DRAIN_INIT = c_DRAIN_W'(DRAIN_CYC);
    localparam logic [c_DRAIN_W-1:0] c_DRAIN_ONE  = c_DRAIN_W'(1);
    localparam logic [CNT_W-1:0]     c_CNT_ONE    = CNT_W'(1);

    // Registered state and outputs
    bj_state_t            r_state;
    logic [c_DRAIN_W-1:0] r_drainCnt;
    logic                 r_exRdy;
    logic                 r_redirVld;
    logic [CPU_WIDTH-1:0] r_redirPc;
    logic                 r_flush;
    logic                 r_kill;
    logic                 r_excVld;
    logic [CPU_WIDTH-1:0] r_excAddr;
    logic [CNT_W-1:0]     r_bjCnt;
    logic [CNT_W-1:0]     r_mispredCnt;

    // Next-state values
    bj_state_t            w_nextState;
    logic [c_DRAIN_W-1:0] w_nextDrainCnt;
    logic                 w_nextExRdy;
    logic                 w_nextRedirVld;
    logic [CPU_WIDTH-1:0] w_nextRedirPc;
    logic                 w_nextFlush;
    logic                 w_nextKill;
    logic                 w_nextExcVld;
    logic [CPU_WIDTH-1:0] w_nextExcAddr;
    logic [CNT_W-1:0]     w_nextBjCnt;
    logic [CNT_W-1:0]     w_nextMispredCnt;

    logic                 w_accept;
    logic                 w_mispred;
    logic                 w_misalign;
    logic [CPU_WIDTH-1:0] w_correctPc;
    bj_cause_t            w_cause;

    rvi_bj_mispred_chk #(
        .CPU_WIDTH (CPU_WIDTH),
        .RVC       (RVC != 0)
    ) u_chk (
        .ex_taken_i      (ex_taken_i),
        .ex_tgt_i        (ex_tgt_i),
        .ex_link_pc_i    (ex_link_pc_i),
        .ex_pred_taken_i (ex_pred_taken_i),
        .ex_pred_tgt_i   (ex_pred_tgt_i),
        .mispred         (w_mispred),
        .misalign        (w_misalign),
        .correct_pc      (w_correctPc)
    );

    assign w_accept = ex_vld_i & r_exRdy;

    // Classify the incoming result; misalignment outranks mispredict
    always_comb begin
        w_cause = CAUSE_NONE;
        if (w_misalign) begin
            w_cause = CAUSE_MISALIGN;
        end else if (w_mispred) begin
            w_cause = CAUSE_MISPRED;
        end
    end

    // Recovery sequencer: next state, next registered outputs, counters
    always_comb begin
        w_nextState      = r_state;
        w_nextDrainCnt   = r_drainCnt;
        w_nextRedirVld   = r_redirVld;
        w_nextRedirPc    = r_redirPc;
        w_nextFlush      = 1'b0;
        w_nextKill       = r_kill;
        w_nextExcVld     = r_excVld;
        w_nextExcAddr    = r_excAddr;
        w_nextBjCnt      = r_bjCnt;
        w_nextMispredCnt = r_mispredCnt;

        case (r_state)
            ST_IDLE: begin
                if (w_accept && ex_is_bj_i) begin
                    if (r_bjCnt != '1) begin
                        w_nextBjCnt = r_bjCnt + c_CNT_ONE;
                    end
                    case (w_cause)
                        CAUSE_MISALIGN: begin
                            w_nextState   = ST_EXC;
                            w_nextExcVld  = 1'b1;
                            w_nextExcAddr = ex_tgt_i;
                            w_nextFlush   = 1'b1;
                            w_nextKill    = 1'b1;
                        end
                        CAUSE_MISPRED: begin
                            w_nextState    = ST_REDIR;
                            w_nextRedirVld = 1'b1;
                            w_nextRedirPc  = w_correctPc;
                            w_nextFlush    = 1'b1;
                            w_nextKill     = 1'b1;
                            if (r_mispredCnt != '1) begin
                                w_nextMispredCnt = r_mispredCnt + c_CNT_ONE;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
            ST_REDIR: begin
                if (redir_rdy_i) begin
                    w_nextRedirVld = 1'b0;
                    if (DRAIN_CYC > 0) begin
                        w_nextState    = ST_DRAIN;
                        w_nextDrainCnt = c_DRAIN_INIT;
                    end else begin
                        w_nextState = ST_IDLE;
                        w_nextKill  = 1'b0;
                    end
                end
            end
            ST_DRAIN: begin
                if (r_drainCnt == c_DRAIN_ONE) begin
                    w_nextState    = ST_IDLE;
                    w_nextKill     = 1'b0;
                    w_nextDrainCnt = '0;
                end else begin
                    w_nextDrainCnt = r_drainCnt - c_DRAIN_ONE;
                end
            end
            ST_EXC: begin
                if (exc_rdy_i) begin
                    w_nextState  = ST_IDLE;
                    w_nextExcVld = 1'b0;
                    w_nextKill   = 1'b0;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase

        w_nextExRdy = (w_nextState == ST_IDLE);
    end

    // State, output and statistics registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_drainCnt   <= '0;
            r_exRdy      <= 1'b1;
            r_redirVld   <= 1'b0;
            r_redirPc    <= '0;
            r_flush      <= 1'b0;
            r_kill       <= 1'b0;
            r_excVld     <= 1'b0;
            r_excAddr    <= '0;
            r_bjCnt      <= '0;
            r_mispredCnt <= '0;
        end else begin
            r_state      <= w_nextState;
            r_drainCnt   <= w_nextDrainCnt;
            r_exRdy      <= w_nextExRdy;
            r_redirVld   <= w_nextRedirVld;
            r_redirPc    <= w_nextRedirPc;
            r_flush      <= w_nextFlush;
            r_kill       <= w_nextKill;
            r_excVld     <= w_nextExcVld;
            r_excAddr    <= w_nextExcAddr;
            r_bjCnt      <= w_nextBjCnt;
            r_mispredCnt <= w_nextMispredCnt;
        end
    end

    assign ex_rdy_o      = r_exRdy;
    assign redir_vld_o   = r_redirVld;
    assign redir_pc_o    = r_redirPc;
    assign flush_o       = r_flush;
    assign kill_o        = r_kill;
    assign exc_vld_o     = r_excVld;
    assign exc_addr_o    = r_excAddr;
    assign bj_cnt_o      = r_bjCnt;
    assign mispred_cnt_o = r_mispredCnt;

endmodule
`default_nettype wire

// File: tb/tb_rvi_bj_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rvi_bj_redirect_ctrl
// Description : Self-checking bench for rvi_bj_redirect_ctrl. Instance 0 has
//               RVC=1/CNT_W=16, instance 1 has RVC=0/CNT_W=4. Expected
//               recoveries are queued when a result is driven and compared
//               when the DUT raises its redirect or exception.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rvi_bj_redirect_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        exVld[2], isBj[2], taken[2], predTaken[2], redirRdy[2], excRdy[2];
    logic [31:0] tgt[2], linkPc[2], predTgt[2];
    logic        exRdy[2], redirVld[2], flush[2], kill[2], excVld[2];
    logic [31:0] redirPc[2], excAddr[2];
    logic [15:0] bjCntA, mpCntA;
    logic [3:0]  bjCntB, mpCntB;

    int nVec = 0;
    int nMis = 0;
    int expBj[2];
    int expMp[2];

    typedef struct {
        bit          isExc;
        logic [31:0] addr;
    } rec_t;
    rec_t sbq[$];

    rvi_bj_redirect_ctrl #(.RV64(0), .RVC(1), .DRAIN_CYC(2), .CNT_W(16)) dutA (
        .clk(clk), .rst(rst),
        .ex_vld_i(exVld[0]), .ex_rdy_o(exRdy[0]), .ex_is_bj_i(isBj[0]),
        .ex_taken_i(taken[0]), .ex_tgt_i(tgt[0]), .ex_link_pc_i(linkPc[0]),
        .ex_pred_taken_i(predTaken[0]), .ex_pred_tgt_i(predTgt[0]),
        .redir_vld_o(redirVld[0]), .redir_rdy_i(redirRdy[0]), .redir_pc_o(redirPc[0]),
        .flush_o(flush[0]), .kill_o(kill[0]),
        .exc_vld_o(excVld[0]), .exc_rdy_i(excRdy[0]), .exc_addr_o(excAddr[0]),
        .bj_cnt_o(bjCntA), .mispred_cnt_o(mpCntA)
    );

    rvi_bj_redirect_ctrl #(.RV64(0), .RVC(0), .DRAIN_CYC(2), .CNT_W(4)) dutB (
        .clk(clk), .rst(rst),
        .ex_vld_i(exVld[1]), .ex_rdy_o(exRdy[1]), .ex_is_bj_i(isBj[1]),
        .ex_taken_i(taken[1]), .ex_tgt_i(tgt[1]), .ex_link_pc_i(linkPc[1]),
        .ex_pred_taken_i(predTaken[1]), .ex_pred_tgt_i(predTgt[1]),
        .redir_vld_o(redirVld[1]), .redir_rdy_i(redirRdy[1]), .redir_pc_o(redirPc[1]),
        .flush_o(flush[1]), .kill_o(kill[1]),
        .exc_vld_o(excVld[1]), .exc_rdy_i(excRdy[1]), .exc_addr_o(excAddr[1]),
        .bj_cnt_o(bjCntB), .mispred_cnt_o(mpCntB)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] bjOf(input int s);
        return (s == 0) ? bjCntA : {12'd0, bjCntB};
    endfunction

    function automatic logic [15:0] mpOf(input int s);
        return (s == 0) ? mpCntA : {12'd0, mpCntB};
    endfunction

    function automatic int maxCnt(input int s);
        return (s == 0) ? 65535 : 15;
    endfunction

    task automatic chkIdle(input int s);
        chk("idle_redir", redirVld[s], 1'b0);
        chk("idle_exc", excVld[s], 1'b0);
        chk("idle_flush", flush[s], 1'b0);
        chk("idle_kill", kill[s], 1'b0);
        chk("idle_rdy", exRdy[s], 1'b1);
        chk("idle_bj_cnt", bjOf(s), expBj[s]);
        chk("idle_mp_cnt", mpOf(s), expMp[s]);
    endtask

    // Called on the first cycle the recovery is visible
    task automatic recover(input int s, input int waitCyc);
        rec_t e;
        int   n;
        n = 0;
        if (sbq.size() == 0) begin
            chk("sb_empty", 1, 0);
            return;
        end
        e = sbq.pop_front();
        if (!e.isExc) begin
            chk("redir_vld", redirVld[s], 1'b1);
            chk("redir_pc", redirPc[s], e.addr);
            chk("exc_quiet", excVld[s], 1'b0);
            for (int i = 0; i < waitCyc; i++) begin
                @(negedge clk);
                chk("redir_hold_vld", redirVld[s], 1'b1);
                chk("redir_hold_pc", redirPc[s], e.addr);
                chk("flush_one_cyc", flush[s], 1'b0);
                chk("redir_kill", kill[s], 1'b1);
            end
            redirRdy[s] = 1'b1;
            @(negedge clk);
            redirRdy[s] = 1'b0;
            chk("redir_drop", redirVld[s], 1'b0);
            while (kill[s] === 1'b1 && n < 10) begin
                n++;
                @(negedge clk);
            end
            chk("drain_len", n, 2);
            chk("rdy_after_drain", exRdy[s], 1'b1);
        end else begin
            chk("exc_vld", excVld[s], 1'b1);
            chk("exc_addr", excAddr[s], e.addr);
            chk("exc_no_redir", redirVld[s], 1'b0);
            for (int i = 0; i < 2; i++) begin
                @(negedge clk);
                chk("exc_hold", excVld[s], 1'b1);
                chk("exc_no_redir_hold", redirVld[s], 1'b0);
                chk("exc_flush_one_cyc", flush[s], 1'b0);
            end
            excRdy[s] = 1'b1;
            @(negedge clk);
            excRdy[s] = 1'b0;
            chk("exc_drop", excVld[s], 1'b0);
            chk("exc_kill_drop", kill[s], 1'b0);
            chk("rdy_after_exc", exRdy[s], 1'b1);
        end
    endtask

    // Drive one result at a negedge; waitCyc<0 leaves any recovery pending
    task automatic send(input int s, input bit bj, input bit tk, input logic [31:0] t,
                        input logic [31:0] lp, input bit ptk, input logic [31:0] pt,
                        input int waitCyc);
        bit   rvc, mal, mp, rec;
        rec_t e;
        chk("rdy_pre", exRdy[s], 1'b1);
        rvc = (s == 0);
        mal = tk && (rvc ? (t[0] == 1'b1) : (t[1:0] != 2'b00));
        mp  = (tk != ptk) || (tk && (t != pt));
        rec = bj && (mal || mp);
        exVld[s] = 1'b1; isBj[s] = bj; taken[s] = tk; tgt[s] = t;
        linkPc[s] = lp; predTaken[s] = ptk; predTgt[s] = pt;
        if (bj) begin
            if (expBj[s] < maxCnt(s)) expBj[s]++;
            if (mp && !mal && expMp[s] < maxCnt(s)) expMp[s]++;
        end
        if (rec) begin
            e.isExc = mal;
            e.addr  = (mal || tk) ? t : lp;
            sbq.push_back(e);
        end
        @(negedge clk);
        exVld[s] = 1'b0;
        chk("flush", flush[s], rec);
        chk("kill", kill[s], rec);
        chk("rdy_post", exRdy[s], !rec);
        chk("bj_cnt", bjOf(s), expBj[s]);
        chk("mp_cnt", mpOf(s), expMp[s]);
        if (!rec) begin
            chk("no_redir", redirVld[s], 1'b0);
            chk("no_exc", excVld[s], 1'b0);
        end else if (waitCyc >= 0) begin
            recover(s, waitCyc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            exVld[i] = 0; isBj[i] = 0; taken[i] = 0; predTaken[i] = 0;
            redirRdy[i] = 0; excRdy[i] = 0; tgt[i] = 0; linkPc[i] = 0; predTgt[i] = 0;
            expBj[i] = 0; expMp[i] = 0;
        end
        repeat (2) @(negedge clk);
        chkIdle(0);
        chkIdle(1);
        rst = 1'b0;

        // Handshake inputs outside their state are ignored
        redirRdy[0] = 1'b1; excRdy[0] = 1'b1;
        @(negedge clk);
        redirRdy[0] = 1'b0; excRdy[0] = 1'b0;
        chkIdle(0);

        // Correct prediction
        send(0, 1, 1, 32'h100, 32'h104, 1, 32'h100, 0);
        // Non-branch result is dropped even with mismatching fields
        send(0, 0, 0, 32'h0, 32'h204, 1, 32'h300, 0);
        // Not-taken mispredict, fetch stalls 3 cycles
        send(0, 1, 0, 32'h0, 32'h204, 1, 32'h208, 3);
        // Wrong target
        send(0, 1, 1, 32'h300, 32'h2fc, 1, 32'h304, 0);
        // RVC=1: halfword target is a normal redirect
        send(0, 1, 1, 32'h102, 32'h0fe, 0, 32'h0, 1);
        // RVC=1: odd target raises the exception
        send(0, 1, 1, 32'h101, 32'h0fe, 0, 32'h0, 0);
        // RVC=0: halfword target raises the exception
        send(1, 1, 1, 32'h102, 32'h0fe, 0, 32'h0, 0);
        // RVC=0: misaligned but correctly predicted still traps
        send(1, 1, 1, 32'h106, 32'h0fe, 1, 32'h106, 0);
        // RVC=0: correct prediction
        send(1, 1, 1, 32'h100, 32'h0fc, 1, 32'h100, 0);
        chkIdle(0);
        chkIdle(1);

        // Reset while a redirect is pending
        send(0, 1, 0, 32'h0, 32'h504, 1, 32'h500, -1);
        chk("pre_rst_redir", redirVld[0], 1'b1);
        sbq.delete();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            expBj[i] = 0; expMp[i] = 0;
        end
        chkIdle(0);
        chkIdle(1);
        @(negedge clk);
        chkIdle(0);

        // Saturation on the 4-bit counters
        for (int k = 0; k < 20; k++) begin
            send(1, 1, 0, 32'h0, 32'h400 + 32'(k * 4), 1, 32'h800, 0);
        end
        chk("sat_bj", bjOf(1), 16'd15);
        chk("sat_mp", mpOf(1), 16'd15);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rvi_bj_redirect_ctrl.md
Name: rvi_bj_redirect_ctrl

Overview:
Controller behind the branch/jump execute datapath. It consumes resolved branch/jump results (taken, target, link PC) and compares them against the front-end prediction. It then sequences recovery: a redirect request to fetch, a one-cycle flush pulse, younger-instruction squash and drain cycles, or a target-misaligned exception. It also keeps saturating branch and mispredict statistics counters.

Parameters:
RV64, 0, 1 selects 64-bit datapath
CPU_WIDTH, 32*(RV64+1), address/data width
RVC, 1, 1 = compressed ISA enabled (halfword-aligned targets legal)
DRAIN_CYC, 2, squash cycles after redirect handshake (0 allowed)
CNT_W, 16, statistics counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ex_vld_i  in  1  execute result valid
ex_rdy_o  out  1  controller can accept a result
ex_is_bj_i  in  1  result is a branch/jump (bjEn)
ex_taken_i  in  1  resolved taken (OR of bjEn result bits)
ex_tgt_i  in  CPU_WIDTH  resolved target address
ex_link_pc_i  in  CPU_WIDTH  fall-through / link PC
ex_pred_taken_i  in  1  predicted taken
ex_pred_tgt_i  in  CPU_WIDTH  predicted target
redir_vld_o  out  1  redirect request to fetch
redir_rdy_i  in  1  fetch accepts redirect
redir_pc_o  out  CPU_WIDTH  correct next PC
flush_o  out  1  one-cycle pipeline flush pulse
kill_o  out  1  squash younger instructions
exc_vld_o  out  1  instruction-address-misaligned exception
exc_rdy_i  in  1  exception accepted by trap unit
exc_addr_o  out  CPU_WIDTH  offending target
bj_cnt_o  out  CNT_W  branches/jumps resolved
mispred_cnt_o  out  CNT_W  mispredicts detected

Behaviour:
- Clock clk; reset rst is synchronous and active-high. Reset forces state IDLE, the drain counter and both statistics counters to 0, and all outputs to 0, except ex_rdy_o, which is 1. Reset mid-operation abandons any pending redirect or exception with no further pulses.
- Accept: ex_vld_i & ex_rdy_o. ex_rdy_o = 1 only in IDLE.
- Accepted results with ex_is_bj_i=0 are dropped with no side effect.
- Mispredict = ex_taken_i != ex_pred_taken_i, OR (ex_taken_i & ex_tgt_i != ex_pred_tgt_i).
- Correct PC = ex_taken_i ? ex_tgt_i : ex_link_pc_i.
- Misalign = ex_taken_i & (RVC ? ex_tgt_i[0] : |ex_tgt_i[1:0]). Misalign has priority over mispredict.
- States: IDLE, REDIR, DRAIN, EXC. All outputs are registered.
- IDLE, accepted bj, no mispredict and no misalign: stay IDLE; bj_cnt +1 next cycle.
- IDLE, accepted bj with mispredict (no misalign): at T+1 enter REDIR. redir_pc_o is latched; redir_vld_o=1; flush_o=1 for exactly cycle T+1; kill_o=1. bj_cnt and mispred_cnt each +1.
- REDIR: hold redir_vld_o and redir_pc_o stable until redir_rdy_i. On handshake:
  - DRAIN_CYC>0: go to DRAIN with counter=DRAIN_CYC.
  - DRAIN_CYC=0: go to IDLE.
  - redir_vld_o drops the cycle after the handshake.
- DRAIN: kill_o=1, counter decrements each cycle. At counter==1, next state is IDLE (exactly DRAIN_CYC cycles in DRAIN).
- IDLE, accepted bj with misalign: at T+1 enter EXC. exc_vld_o=1, exc_addr_o=ex_tgt_i, flush_o=1 for one cycle, kill_o=1. bj_cnt +1; mispred_cnt unchanged. EXC holds until exc_rdy_i, then IDLE. No redirect is issued.
- kill_o=1 in REDIR, DRAIN and EXC; 0 in IDLE.
- Counters saturate at all-ones; no wrap.
- redir_rdy_i or exc_rdy_i asserted outside the matching state is ignored.
- Target arithmetic is done upstream; this block performs no addition, only width-CPU_WIDTH compares.

Decomposition:
- Package rvi_bj_ctrl_pkg holds:
  - state enum (IDLE, REDIR, DRAIN, EXC);
  - recovery-cause enum (NONE, MISPRED, MISALIGN);
  - width function for the drain counter, $clog2(DRAIN_CYC+1).
- One combinational sub-module, rvi_bj_mispred_chk: inputs are the ex_* fields plus RVC; outputs are mispred, misalign and correct_pc. The FSM, counters and output registers stay in the top.

Test Plan:
- Correct prediction: taken=1, pred_taken=1, tgt=pred_tgt=0x100 -> no redir_vld_o, flush_o=0, bj_cnt=1, mispred_cnt=0, ex_rdy_o stays 1.
- Not-taken mispredict: taken=0, pred_taken=1, link_pc=0x204 -> next cycle redir_vld_o=1, redir_pc_o=0x204, flush_o high exactly 1 cycle; with redir_rdy_i held 0 for 3 cycles the request stays stable; after handshake kill_o stays 1 for exactly 2 cycles (DRAIN_CYC=2), then ex_rdy_o=1.
- Wrong target: taken=1, pred_taken=1, tgt=0x300, pred_tgt=0x304 -> redir_pc_o=0x300, mispred_cnt=1.
- Misalign: RVC=0, taken=1, tgt=0x102 -> exc_vld_o=1, exc_addr_o=0x102, redir_vld_o never set; with RVC=1 the same target gives a normal redirect, and tgt=0x101 raises the exception.
- Reset mid-REDIR: assert rst while redir_vld_o=1 -> next cycle all outputs 0, ex_rdy_o=1, counters 0.
- Saturation: CNT_W=4, 20 mispredicts -> mispred_cnt_o=15, bj_cnt_o=15.
